// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers and fixed-latency multicycle operations.
// Arithmetic is computed combinationally from latched operands and committed when the busy count expires.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic        read_sel,
    output logic        busy,
    output logic [31:0] result
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic { S_IDLE, S_BUSY } state_t;

    state_t      r_state;
    logic        r_busy;
    logic [CW-1:0] r_cnt;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_signed;
    logic        w_is_div;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_ua;
    logic [31:0] w_ub;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_hi;
    logic [31:0] w_lo;
    logic        w_commit;

    // op[0] selects the unsigned variant, op[1] selects divide.
    assign w_signed = ~r_op[0];
    assign w_is_div = r_op[1];

    assign w_prod = {{32{r_a[31] & w_signed}}, r_a} * {{32{r_b[31] & w_signed}}, r_b};

    // Divide on magnitudes so the most-negative dividend needs no special case.
    assign w_a_neg = r_a[31] & w_signed;
    assign w_b_neg = r_b[31] & w_signed;
    assign w_ua    = w_a_neg ? -r_a : r_a;
    assign w_ub    = w_b_neg ? -r_b : r_b;
    assign w_uq    = (w_ub == 32'd0) ? 32'd0 : w_ua / w_ub;
    assign w_ur    = (w_ub == 32'd0) ? 32'd0 : w_ua % w_ub;

    always_comb begin
        w_hi = w_prod[63:32];
        w_lo = w_prod[31:0];
        if (w_is_div) begin
            w_lo = (w_a_neg ^ w_b_neg) ? -w_uq : w_uq;
            w_hi = w_a_neg ? -w_ur : w_ur;
        end
    end

    assign w_commit = ~(w_is_div && (r_b == 32'd0));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_op    <= 2'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                r_op    <= op[1:0];
                                r_a     <= operand1;
                                r_b     <= operand2;
                                r_cnt   <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                                r_state <= S_BUSY;
                                r_busy  <= 1'b1;
                            end
                            3'd4:    r_hi <= operand1;
                            3'd5:    r_lo <= operand1;
                            default: ;
                        endcase
                    end
                end
                S_BUSY: begin
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        if (w_commit) begin
                            r_hi <= w_hi;
                            r_lo <= w_lo;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign result = read_sel ? r_hi : r_lo;
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: table-driven multiply/divide vectors through a scoreboard queue,
// plus hand-written sequences for MTHI/MTLO, reserved ops, divide by zero and reset abort.
module tb_mdu;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] operand1 = 32'd0;
    logic [31:0] operand2 = 32'd0;
    logic        read_sel = 1'b0;
    logic        busy;
    logic [31:0] result;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand1(operand1), .operand2(operand2), .read_sel(read_sel),
        .busy(busy), .result(result)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic read_reg(input logic sel, output logic [31:0] v);
        read_sel = sel;
        #1;
        v = result;
    endtask

    // Issue one multiply/divide, scramble inputs while busy, count busy cycles, then check HI/LO.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int n, input logic poke_mthi);
        exp_t e;
        logic [31:0] v;
        int cyc;
        @(negedge clk);
        start = 1'b1; op = o; operand1 = a; operand2 = b;
        e.hi = exp_hi; e.lo = exp_lo;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        operand1 = $urandom; operand2 = $urandom; op = 3'($urandom_range(0, 7));
        cyc = 0;
        while (busy === 1'b1 && cyc < 50) begin
            cyc++;
            if (cyc == 1) begin
                read_reg(1'b1, v); check({name, " hi during busy"}, v, m_hi);
                read_reg(1'b0, v); check({name, " lo during busy"}, v, m_lo);
            end
            if (cyc == 2 && poke_mthi) begin
                start = 1'b1; op = 3'd4; operand1 = 32'hDEADBEEF;
            end
            if (cyc == 3) start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check({name, " busy cycles"}, 32'(cyc), 32'(n));
        e = sb_q.pop_front();
        read_reg(1'b1, v); check({name, " hi"}, v, e.hi);
        read_reg(1'b0, v); check({name, " lo"}, v, e.lo);
        m_hi = e.hi; m_lo = e.lo;
        $display("op %-22s a=%08h b=%08h busy=%0d hi=%08h lo=%08h", name, a, b, cyc, e.hi, e.lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        vecs[0]  = '{"MULT -2*3",        3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{"MULTU max*max",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{"DIV -7/2",         3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"DIV min/-1",       3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{"DIVU 7/2",         3'd3, 32'd7,        32'd2,        32'd1,        32'd3};
        vecs[5]  = '{"MULT 2^16*2^16",   3'd0, 32'h00010000, 32'h00010000, 32'd1,        32'd0};
        vecs[6]  = '{"DIV 7/-2",         3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[7]  = '{"MULTU 2^31*2",     3'd1, 32'h80000000, 32'd2,        32'd1,        32'd0};
        vecs[8]  = '{"MULT min*2",       3'd0, 32'h80000000, 32'd2,        32'hFFFFFFFF, 32'd0};
        vecs[9]  = '{"DIVU max/16",      3'd3, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF};
        vecs[10] = '{"DIV -8/-3",        3'd2, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        read_reg(1'b1, v); check("reset hi", v, 32'd0);
        read_reg(1'b0, v); check("reset lo", v, 32'd0);

        // Reset wins over a simultaneous start
        start = 1'b1; op = 3'd5; operand1 = 32'hAAAA5555;
        @(negedge clk);
        read_reg(1'b0, v); check("reset priority lo", v, 32'd0);

        // First edge with reset released accepts a start
        reset = 1'b1; op = 3'd4; operand1 = 32'h0BADF00D;
        @(negedge clk);
        start = 1'b0;
        check("first start busy", {31'd0, busy}, 32'd0);
        read_reg(1'b1, v); check("first start hi", v, 32'h0BADF00D);
        m_hi = 32'h0BADF00D;
        $display("op %-22s hi=%08h", "MTHI after reset", v);

        for (int i = 0; i < 11; i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                   (vecs[i].op < 3'd2) ? 5 : 10, 1'b0);

        run_op("DIVU 7/0", 3'd3, 32'd7, 32'd0, m_hi, m_lo, 10, 1'b0);

        // MTLO visible next cycle with no busy
        @(negedge clk);
        start = 1'b1; op = 3'd5; operand1 = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        check("MTLO busy", {31'd0, busy}, 32'd0);
        read_reg(1'b0, v); check("MTLO lo", v, 32'h12345678);
        m_lo = 32'h12345678;
        $display("op %-22s lo=%08h", "MTLO", v);

        // Reserved ops do nothing
        for (int r = 6; r < 8; r++) begin
            @(negedge clk);
            start = 1'b1; op = 3'(r); operand1 = 32'hFFFFFFFF; operand2 = 32'hFFFFFFFF;
            @(negedge clk);
            start = 1'b0;
            check("reserved busy", {31'd0, busy}, 32'd0);
            read_reg(1'b1, v); check("reserved hi", v, m_hi);
            read_reg(1'b0, v); check("reserved lo", v, m_lo);
            $display("op %-22s op=%0d", "reserved", r);
        end

        // MTHI issued while busy is ignored
        run_op("DIV 100/7 +MTHI poke", 3'd2, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1'b1);

        // Reset during the 4th busy cycle aborts without a late commit
        @(negedge clk);
        start = 1'b1; op = 3'd2; operand1 = 32'hFFFFFFF9; operand2 = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort busy before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort busy", {31'd0, busy}, 32'd0);
        read_reg(1'b1, v); check("abort hi", v, 32'd0);
        read_reg(1'b0, v); check("abort lo", v, 32'd0);
        repeat (15) @(negedge clk);
        read_reg(1'b1, v); check("abort late hi", v, 32'd0);
        read_reg(1'b0, v); check("abort late lo", v, 32'd0);
        check("abort late busy", {31'd0, busy}, 32'd0);
        $display("op %-22s hi=%08h lo=%08h", "DIV aborted by reset", 32'd0, v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
